logic_24: RTL and testbench
===========================

// Module: logic_24
// PURPOSE
//   Time-keeping core of the digital clock: a 24-hour HH:MM counter held as packed BCD.
//   In run mode it advances one minute on every clock edge where the minute carry-in is high.
//   In modify mode the user sets hours or minutes with the add button.
//   Outputs drive the display decoder stage: display0 = minutes, display1 = hours.
// PARAMETERS
//   MIN_MOD   60   minute modulus; the minute field counts 0..MIN_MOD-1
//   HOUR_MOD  24   hour modulus; the hour field counts 0..HOUR_MOD-1
// PORTS
//   clk       in   1  single system clock, rising-edge
//   rst       in   1  reset, asynchronous, active-low
//   add       in   1  user increment request, used only in modify mode
//   minute    in   1  run mode: minute carry-in (tick); modify mode: field select (1=minutes, 0=hours)
//   modify    in   1  1 = set-time mode, 0 = run mode
//   display0  out  8  minutes as packed BCD {tens[7:4], ones[3:0]}, 0x00..0x59
//   display1  out  8  hours as packed BCD {tens[7:4], ones[3:0]}, 0x00..0x23
// BEHAVIOUR
//   - Reset: rst=0 forces display0=0x00 and display1=0x00 immediately, with no clock needed.
//     The add edge-detect register also clears to 0. No other state exists.
//   - Outputs are registered, with no combinational path from any input to any output.
//   - Run mode (modify=0), add ignored:
//     - minute=1 at a posedge: minutes +1, latency 1 cycle.
//     - minutes 0x59 -> 0x00 and hours +1 in the same edge.
//     - 23:59 -> 00:00.
//     - minute=0: hold.
//   - Modify mode (modify=1), run ticks suppressed:
//     - Each add increment step raises the field chosen by minute by 1.
//     - minute=1 selects minutes: wrap 0x59 -> 0x00 with NO carry into hours.
//     - minute=0 selects hours: wrap 0x23 -> 0x00.
//   - BCD arithmetic: the ones digit wraps 9 -> 0 and increments tens. The field compare
//     is done on the whole BCD value (MIN_MOD-1 or HOUR_MOD-1 in BCD), never on binary.
//   - modify toggling mid-count takes effect on the next edge; the stored time is kept.
//   - add and minute changing on the same edge: the values sampled at that edge decide.
//   - The outputs never hold a non-BCD or out-of-range value.
// CONFIGURATION
//   - LOGIC24_ADD_EDGE_EN defined:
//     - add is registered and rising-edge detected.
//     - One increment per 0->1 transition, so a held button gives a single step.
//     - The first increment is seen one cycle after add rises.
//   - LOGIC24_ADD_EDGE_EN undefined:
//     - No edge register.
//     - Every posedge with modify=1 and add=1 increments the selected field (level mode).
// STRUCTURE
//   - logic24_pkg: localparams for BCD MIN_MAX=8'h59 and HOUR_MAX=8'h23,
//     typedef bcd2_t = logic [7:0], and function bcd_inc(bcd2_t v, bcd2_t max) -> bcd2_t.
//   - Sub-module bcd_mod_counter (param MAX_BCD; ports clk, rst, inc, q[7:0], wrap):
//     - Instance u_min: inc = run tick | modify-minute step.
//     - Instance u_hr: inc = (run tick & u_min.wrap) | modify-hour step.
// TESTING
//   1. Hold rst=0 for 1 cycle, then release with all inputs 0:
//      display0=0x00 and display1=0x00, stable for 10 cycles.
//   2. Release rst, then set minute=1 and modify=0 for 60 cycles:
//      display0 steps 0x01..0x59, then display0=0x00 and display1=0x01.
//   3. Preload 23:59 via modify, then run mode with one tick:
//      display1=0x00 and display0=0x00 (full wrap).
//   4. Modify mode, minute=1, at 00:59: one add step gives 00:00 (hours unchanged).
//      Then minute=0 with 24 add steps: hours return to 0x00.
//   5. Modify=1 with minute=1 held for 20 cycles and add=0: time unchanged (ticks suppressed).
//   6. Macro on: add held high for 5 cycles -> exactly +1. Macro off: same stimulus -> +5.
//      Also assert rst mid-count: outputs go to 0x00 asynchronously, before the next edge.

Source files
------------

// File: rtl/logic_24_pkg.sv
// Shared types, BCD limits and BCD increment helpers for the logic_24 HH:MM clock core.
package logic24_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // Elaboration-time conversion of a modulus limit (0..99) to packed BCD.
  function automatic bcd2_t bin_to_bcd(int v);
    bcd2_t r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // The limit compare is on the whole BCD value, so only legal BCD codes are ever produced.
  function automatic bcd2_t bcd_inc(bcd2_t v, bcd2_t max);
    bcd2_t r;
    if (v == max) begin
      r = '0;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/logic_24_bcd_mod_counter.sv
// Two-digit BCD counter 0..MAX_BCD, one step per cycle when inc is high.
// wrap flags the terminal count so the next counter up can chain its carry.
module bcd_mod_counter
  import logic24_pkg::*;
#(
  parameter bcd2_t MAX_BCD = MIN_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] q,
  output logic       wrap
);

  bcd2_t cnt_q;
  bcd2_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = bcd_inc(cnt_q, MAX_BCD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = (cnt_q == MAX_BCD);

endmodule

// File: rtl/logic_24.sv
// 24-hour HH:MM BCD time core: run mode counts minute ticks, modify mode steps the selected field.
// Define LOGIC24_ADD_EDGE_EN to step once per add press instead of once per cycle add is held.
module logic_24
  import logic24_pkg::*;
#(
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add,
  input  logic       minute,
  input  logic       modify,
  output logic [7:0] display0,
  output logic [7:0] display1
);

  localparam bcd2_t MIN_TOP  = bin_to_bcd(MIN_MOD - 1);
  localparam bcd2_t HOUR_TOP = bin_to_bcd(HOUR_MOD - 1);

  logic  add_step;
  logic  run_tick;
  logic  min_inc;
  logic  hr_inc;
  logic  min_wrap;
  logic  hr_wrap;
  bcd2_t min_bcd;
  bcd2_t hr_bcd;

`ifdef LOGIC24_ADD_EDGE_EN
  logic add_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_q <= 1'b0;
    end else begin
      add_q <= add;
    end
  end

  assign add_step = add & ~add_q;
`else
  assign add_step = add;
`endif

  // In modify mode minute is a field select, so it must never be read as a tick.
  assign run_tick = ~modify & minute;
  assign min_inc  = run_tick | (modify & minute & add_step);
  assign hr_inc   = (run_tick & min_wrap) | (modify & ~minute & add_step);

  bcd_mod_counter #(
    .MAX_BCD (MIN_TOP)
  ) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .q    (min_bcd),
    .wrap (min_wrap)
  );

  bcd_mod_counter #(
    .MAX_BCD (HOUR_TOP)
  ) u_hr (
    .clk  (clk),
    .rst  (rst),
    .inc  (hr_inc),
    .q    (hr_bcd),
    .wrap (hr_wrap)
  );

  assign display0 = min_bcd;
  assign display1 = hr_bcd;

  logic unused_ok;
  assign unused_ok = hr_wrap;

endmodule

// File: tb/tb_logic_24.sv
// Randomized and directed checks of logic_24 against an integer hours/minutes model.
module tb_logic_24;

  logic       clk;
  logic       rst;
  logic       add;
  logic       minute;
  logic       modify;
  logic [7:0] display0;
  logic [7:0] display1;

  int n_vec;
  int n_err;

  int mdl_min;
  int mdl_hr;
  bit mdl_prev_add;

  logic_24 dut (
    .clk      (clk),
    .rst      (rst),
    .add      (add),
    .minute   (minute),
    .modify   (modify),
    .display0 (display0),
    .display1 (display1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_min      = 0;
    mdl_hr       = 0;
    mdl_prev_add = 1'b0;
  endtask

  // Clock-rule model: one call per rising edge with the inputs sampled at that edge.
  task automatic model_edge();
    bit step;
`ifdef LOGIC24_ADD_EDGE_EN
    step = add && !mdl_prev_add;
`else
    step = add;
`endif
    mdl_prev_add = add;
    if (!modify) begin
      if (minute) begin
        mdl_min = mdl_min + 1;
        if (mdl_min == 60) begin
          mdl_min = 0;
          mdl_hr  = (mdl_hr + 1) % 24;
        end
      end
    end else if (step) begin
      if (minute) mdl_min = (mdl_min + 1) % 60;
      else        mdl_hr  = (mdl_hr + 1) % 24;
    end
  endtask

  task automatic check_model(input string tag);
    check_val({tag, ".min"}, display0, to_bcd(mdl_min));
    check_val({tag, ".hr"},  display1, to_bcd(mdl_hr));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_edge();
    else     model_reset();
    #1;
    check_model(tag);
  endtask

  task automatic step_add(input logic sel);
    minute = sel;
    add    = 1'b1;
    tick("step");
    add    = 1'b0;
    tick("step_idle");
  endtask

  // Reset asserted between edges must clear the outputs before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    tick({tag, "_hold"});
    rst = 1'b1;
  endtask

  initial begin
    int base;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b0;
    add    = 1'b0;
    minute = 1'b0;
    modify = 1'b0;
    model_reset();

    // 1: reset state and idle stability
    #1;
    check_model("rst_async");
    tick("rst");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick("idle");

    // 2: sixty run ticks roll minutes into hours
    minute = 1'b1;
    for (int i = 0; i < 60; i++) tick("run60");
    check_val("run60.min_end", display0, 8'h00);
    check_val("run60.hr_end",  display1, 8'h01);
    minute = 1'b0;

    // 3: preload 23:59 then one run tick wraps the whole day
    modify = 1'b1;
    for (int i = 0; i < 22; i++) step_add(1'b0);
    for (int i = 0; i < 59; i++) step_add(1'b1);
    check_val("pre.min", display0, 8'h59);
    check_val("pre.hr",  display1, 8'h23);
    modify = 1'b0;
    minute = 1'b1;
    tick("daywrap");
    check_val("daywrap.min", display0, 8'h00);
    check_val("daywrap.hr",  display1, 8'h00);
    minute = 1'b0;
    tick("settle");

    // 4: modify minute wrap has no carry; 24 hour steps come full circle
    modify = 1'b1;
    for (int i = 0; i < 59; i++) step_add(1'b1);
    check_val("m59.min", display0, 8'h59);
    step_add(1'b1);
    check_val("mwrap.min", display0, 8'h00);
    check_val("mwrap.hr",  display1, 8'h00);
    for (int i = 0; i < 23; i++) step_add(1'b0);
    check_val("h23.hr", display1, 8'h23);
    step_add(1'b0);
    check_val("hwrap.hr", display1, 8'h00);

    // 5: ticks suppressed in modify mode
    step_add(1'b1);
    minute = 1'b1;
    add    = 1'b0;
    for (int i = 0; i < 20; i++) tick("suppress");
    check_val("suppress.min", display0, 8'h01);

    // 6: held add, then mid-count asynchronous reset
    base = mdl_min;
    add  = 1'b1;
    for (int i = 0; i < 5; i++) tick("held");
    add = 1'b0;
    tick("held_rel");
`ifdef LOGIC24_ADD_EDGE_EN
    check_val("held.delta", display0, to_bcd(base + 1));
`else
    check_val("held.delta", display0, to_bcd(base + 5));
`endif
    modify = 1'b0;
    for (int i = 0; i < 7; i++) tick("prerst");
    async_reset("midrst");

    // Random mix of modes, selects, buttons and occasional resets
    for (int i = 0; i < 4000; i++) begin
      modify = ($urandom_range(0, 3) == 0);
      minute = ($urandom_range(0, 3) != 0);
      add    = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      else                             tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
